// File: rtl/cbfp_pkg.sv
// Shared definitions for the multi-beat CBFP normaliser.
//   sign_cnt     : redundant sign-bit count of the low w bits of x (0..w-1)
//   idx_width    : width of the block shift index for a given input width
//   round_shift  : arithmetic right shift, optionally rounding half up
//   saturate     : clamp to a w-bit signed range
//   drain_state_e: drain FSM states
// Build option: define CBFP_ROUND_EN to round half up before the right shift;
// otherwise the shift truncates. Saturation is applied in both builds.
package cbfp_pkg;

    typedef enum logic {StIdle, StDrain} drain_state_e;

    function automatic int unsigned idx_width(input int unsigned in_w);
        return $clog2(in_w);
    endfunction

    // Counts bits below bit w-1 that match it, stopping at the first mismatch.
    function automatic logic [7:0] sign_cnt(input logic [63:0] x, input int unsigned w);
        logic [7:0] c;
        logic       run;
        c   = '0;
        run = 1'b1;
        for (int i = 62; i >= 0; i--) begin
            if ((i < int'(w) - 1) && run) begin
                if (x[i] == x[w-1]) c = c + 8'd1;
                else                run = 1'b0;
            end
        end
        return c;
    endfunction

    // Done in 64 bits so the rounding increment cannot wrap; saturation follows.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                       input int unsigned sh);
        logic signed [63:0] t;
        t = v;
`ifdef CBFP_ROUND_EN
        t = t + (64'sd1 <<< (sh - 1));
`endif
        return t >>> sh;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/cbfp_beat_min.sv
// Combinational minimum sign-bit count over all re/im samples of one beat.
// Ports:
//   data_re, data_im : NCHAN packed signed samples of IN_W bits each
//   beat_min         : min of sign_cnt over the 2*NCHAN samples (IN_W-1 when all are 0/-1)
module cbfp_beat_min
    import cbfp_pkg::*;
#(
    parameter int unsigned IN_W  = 25,
    parameter int unsigned NCHAN = 16,
    parameter int unsigned IDX_W = idx_width(IN_W)
) (
    input  logic [NCHAN-1:0][IN_W-1:0] data_re,
    input  logic [NCHAN-1:0][IN_W-1:0] data_im,
    output logic [IDX_W-1:0]           beat_min
);

    always_comb begin
        logic [7:0] m;
        logic [7:0] c;
        m = 8'(IN_W - 1);
        c = '0;
        for (int i = 0; i < int'(NCHAN); i++) begin
            c = sign_cnt(64'(data_re[i]), IN_W);
            if (c < m) m = c;
            c = sign_cnt(64'(data_im[i]), IN_W);
            if (c < m) m = c;
        end
        beat_min = m[IDX_W-1:0];
    end

endmodule

// File: rtl/cbfp_blk_norm.sv
// Multi-beat convergent block-floating-point normaliser.
// A block of BLK_CYCLES input beats is ping-pong buffered, then re-emitted as a
// contiguous burst with every sample shifted left by the block-common sign-bit
// count, right-shifted to OUT_W, and saturated.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   valid_in                  : input beat strobe (gaps allowed)
//   data_re_in, data_im_in    : NCHAN signed IN_W-bit samples
//   valid_out, sop, eop       : output burst strobe, first / last beat flags
//   data_re_out, data_im_out  : NCHAN signed OUT_W-bit normalised samples
//   blk_idx                   : block shift index, constant for the burst
// Build option: CBFP_ROUND_EN selects round-half-up instead of truncation.
// Latency: valid_out rises on the 3rd edge after the block's last beat is sampled.
module cbfp_blk_norm
    import cbfp_pkg::*;
#(
    parameter int unsigned IN_W       = 25,
    parameter int unsigned OUT_W      = 12,
    parameter int unsigned NCHAN      = 16,
    parameter int unsigned BLK_CYCLES = 4,
    parameter int unsigned IDX_W      = idx_width(IN_W)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [NCHAN-1:0][IN_W-1:0]   data_re_in,
    input  logic [NCHAN-1:0][IN_W-1:0]   data_im_in,
    output logic                         valid_out,
    output logic [NCHAN-1:0][OUT_W-1:0]  data_re_out,
    output logic [NCHAN-1:0][OUT_W-1:0]  data_im_out,
    output logic [IDX_W-1:0]             blk_idx,
    output logic                         sop,
    output logic                         eop
);

    localparam int unsigned      CNT_W   = (BLK_CYCLES > 1) ? $clog2(BLK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(BLK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(IN_W - 1);
    localparam int unsigned      SHR     = IN_W - OUT_W;

    // Stage 1: register beat data and its minimum sign-bit count.
    logic [IDX_W-1:0]           beat_min;
    logic                       s1_valid;
    logic [NCHAN-1:0][IN_W-1:0] s1_re, s1_im;
    logic [IDX_W-1:0]           s1_min;

    cbfp_beat_min #(
        .IN_W  (IN_W),
        .NCHAN (NCHAN),
        .IDX_W (IDX_W)
    ) u_beat_min (
        .data_re  (data_re_in),
        .data_im  (data_im_in),
        .beat_min (beat_min)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_min   <= '0;
        end else begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_re  <= data_re_in;
                s1_im  <= data_im_in;
                s1_min <= beat_min;
            end
        end
    end

    // Stage 2: bank write, running minimum, bank swap at block end.
    logic [CNT_W-1:0] wr_cnt_q;
    logic [IDX_W-1:0] run_min_q, idx_pend_q, merged_min;
    logic             fill_bank_q, swap_pend_q, blk_end, drain_start;

    logic [NCHAN-1:0][IN_W-1:0] bank_re [2][BLK_CYCLES];
    logic [NCHAN-1:0][IN_W-1:0] bank_im [2][BLK_CYCLES];

    assign merged_min = (s1_min < run_min_q) ? s1_min : run_min_q;
    assign blk_end    = s1_valid && (wr_cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            run_min_q   <= IDX_MAX;
            idx_pend_q  <= '0;
            fill_bank_q <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            if (s1_valid) begin
                if (wr_cnt_q == LAST) begin
                    wr_cnt_q    <= '0;
                    run_min_q   <= IDX_MAX;
                    idx_pend_q  <= merged_min;
                    fill_bank_q <= ~fill_bank_q;
                end else begin
                    wr_cnt_q  <= wr_cnt_q + 1'b1;
                    run_min_q <= merged_min;
                end
            end
            if (blk_end)          swap_pend_q <= 1'b1;
            else if (drain_start) swap_pend_q <= 1'b0;
        end
    end

    // Bank contents need no reset: nothing is read until a full block has landed.
    always_ff @(posedge clk) begin
        if (s1_valid) begin
            bank_re[fill_bank_q][wr_cnt_q] <= s1_re;
            bank_im[fill_bank_q][wr_cnt_q] <= s1_im;
        end
    end

    // Drain FSM. Bank select and index are captured on entry because the fill
    // side may swap again while the last beat of this burst is still being read.
    drain_state_e     state_q, state_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             drain_bank_q, drain_bank_d;
    logic [IDX_W-1:0] drain_idx_q, drain_idx_d;

    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        drain_bank_d = drain_bank_q;
        drain_idx_d  = drain_idx_q;
        drain_start  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (swap_pend_q) drain_start = 1'b1;
            end
            StDrain: begin
                if (rd_cnt_q == LAST) begin
                    if (swap_pend_q) drain_start = 1'b1;
                    else             state_d     = StIdle;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (drain_start) begin
            state_d      = StDrain;
            rd_cnt_d     = '0;
            drain_bank_d = ~fill_bank_q;
            drain_idx_d  = idx_pend_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rd_cnt_q     <= '0;
            drain_bank_q <= 1'b0;
            drain_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            drain_bank_q <= drain_bank_d;
            drain_idx_q  <= drain_idx_d;
        end
    end

    // Stage 3: normalise the drained beat and register the outputs.
    logic [NCHAN-1:0][OUT_W-1:0] norm_re, norm_im;

    always_comb begin
        logic signed [IN_W-1:0] sh;
        logic signed [63:0]     r;
        sh = '0;
        r  = '0;
        for (int c = 0; c < int'(NCHAN); c++) begin
            sh         = $signed(bank_re[drain_bank_q][rd_cnt_q][c]) <<< drain_idx_q;
            r          = saturate(round_shift(64'(sh), SHR), OUT_W);
            norm_re[c] = r[OUT_W-1:0];
            sh         = $signed(bank_im[drain_bank_q][rd_cnt_q][c]) <<< drain_idx_q;
            r          = saturate(round_shift(64'(sh), SHR), OUT_W);
            norm_im[c] = r[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out   <= 1'b0;
            sop         <= 1'b0;
            eop         <= 1'b0;
            data_re_out <= '0;
            data_im_out <= '0;
            blk_idx     <= '0;
        end else if (state_q == StDrain) begin
            valid_out   <= 1'b1;
            sop         <= (rd_cnt_q == '0);
            eop         <= (rd_cnt_q == LAST);
            data_re_out <= norm_re;
            data_im_out <= norm_im;
            blk_idx     <= drain_idx_q;
        end else begin
            valid_out <= 1'b0;
            sop       <= 1'b0;
            eop       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cbfp_blk_norm.sv
// Scoreboard bench for cbfp_blk_norm with default parameters. Stimulus pushes
// hand-computed expected beats (with their expected arrival cycle); a monitor on
// the falling edge pops and compares whenever valid_out is high.
module tb_cbfp_blk_norm;

    localparam int IN_W  = 25;
    localparam int OUT_W = 12;
    localparam int NCHAN = 16;
    localparam int BLK   = 4;
    localparam int IDX_W = 5;
`ifdef CBFP_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        valid_in = 1'b0;
    logic [NCHAN-1:0][IN_W-1:0]  data_re_in = '0;
    logic [NCHAN-1:0][IN_W-1:0]  data_im_in = '0;
    logic                        valid_out, sop, eop;
    logic [NCHAN-1:0][OUT_W-1:0] data_re_out, data_im_out;
    logic [IDX_W-1:0]            blk_idx;

    cbfp_blk_norm dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .data_re_in  (data_re_in),
        .data_im_in  (data_im_in),
        .valid_out   (valid_out),
        .data_re_out (data_re_out),
        .data_im_out (data_im_out),
        .blk_idx     (blk_idx),
        .sop         (sop),
        .eop         (eop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int re [NCHAN];
        int im [NCHAN];
        int idx;
        bit sop;
        bit eop;
        int cyc;
    } exp_t;

    exp_t sb [$];

    int in_re  [BLK][NCHAN];
    int in_im  [BLK][NCHAN];
    int exp_re [BLK][NCHAN];
    int exp_im [BLK][NCHAN];
    int exp_idx;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got valid_out=1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                int   dre, dim, ere, eim;
                bit   ok_re, ok_im;
                e = sb.pop_front();
                check("arrival_cycle", cyc, e.cyc);
                check("blk_idx", int'(blk_idx), e.idx);
                check("sop", int'(sop), int'(e.sop));
                check("eop", int'(eop), int'(e.eop));
                ok_re = 1'b1;
                ok_im = 1'b1;
                for (int c = NCHAN - 1; c >= 0; c--) begin
                    if (int'($signed(data_re_out[c])) != e.re[c]) begin
                        ok_re = 1'b0;
                        dre   = int'($signed(data_re_out[c]));
                        ere   = e.re[c];
                    end
                    if (int'($signed(data_im_out[c])) != e.im[c]) begin
                        ok_im = 1'b0;
                        dim   = int'($signed(data_im_out[c]));
                        eim   = e.im[c];
                    end
                end
                total += 2;
                if (!ok_re) begin
                    bad++;
                    $display("FAIL data_re: got %0d expected %0d (cycle %0d)", dre, ere, cyc);
                end
                if (!ok_im) begin
                    bad++;
                    $display("FAIL data_im: got %0d expected %0d (cycle %0d)", dim, eim, cyc);
                end
            end
        end
    end

    task automatic set_all(input int vr, input int vi, input int er, input int ei,
                           input int idx);
        for (int b = 0; b < BLK; b++) begin
            for (int c = 0; c < NCHAN; c++) begin
                in_re[b][c]  = vr;
                in_im[b][c]  = vi;
                exp_re[b][c] = er;
                exp_im[b][c] = ei;
            end
        end
        exp_idx = idx;
    endtask

    task automatic drive_beat(input int b);
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        for (int c = 0; c < NCHAN; c++) begin
            data_re_in[c] = IN_W'(in_re[b][c]);
            data_im_in[c] = IN_W'(in_im[b][c]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
        end
    endtask

    // The last beat is sampled on edge n+1; the burst starts on edge n+4.
    task automatic send_block(input bit gapped);
        int   n;
        exp_t e;
        n = 0;
        for (int b = 0; b < BLK; b++) begin
            drive_beat(b);
            n = cyc;
            if (gapped) idle(1);
        end
        for (int b = 0; b < BLK; b++) begin
            for (int c = 0; c < NCHAN; c++) begin
                e.re[c] = exp_re[b][c];
                e.im[c] = exp_im[b][c];
            end
            e.idx = exp_idx;
            e.sop = (b == 0);
            e.eop = (b == BLK - 1);
            e.cyc = n + 4 + b;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("pending_after_drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_out", int'(valid_out), 0);
        check("reset_sop", int'(sop), 0);
        check("reset_eop", int'(eop), 0);
        check("reset_blk_idx", int'(blk_idx), 0);
        check("reset_data_re_nonzero", int'(data_re_out != '0), 0);
        check("reset_data_im_nonzero", int'(data_im_out != '0), 0);
        rst = 1'b0;
        idle(2);

        // Four back-to-back blocks: bursts must be contiguous.
        set_all(4096, 4096, 1024, 1024, 11);
        send_block(1'b0);
        set_all(8192, 8192, 1, 1, 0);
        in_re[2][5]  = -(1 << 24);
        exp_re[2][5] = -2048;
        send_block(1'b0);
        set_all(0, 0, 0, 0, 24);
        send_block(1'b0);
        set_all(4096, 4096, RND, RND, 0);
        in_re[0][0]  = (1 << 24) - 1;
        exp_re[0][0] = 2047;
        send_block(1'b0);
        idle(1);
        wait_drain();

        // Gapped input, two blocks with per-sample distinct data.
        exp_idx = 12;
        for (int b = 0; b < BLK; b++) begin
            for (int c = 0; c < NCHAN; c++) begin
                in_re[b][c]  = 64 * (16 * b + c);
                in_im[b][c]  = -64 * (16 * b + c) - 64;
                exp_re[b][c] = 32 * (16 * b + c);
                exp_im[b][c] = -32 * (16 * b + c) - 32;
            end
        end
        send_block(1'b1);
        exp_idx = 14;
        for (int b = 0; b < BLK; b++) begin
            for (int c = 0; c < NCHAN; c++) begin
                in_re[b][c]  = 16 * (16 * b + c);
                in_im[b][c]  = 16 * (63 - (16 * b + c));
                exp_re[b][c] = 32 * (16 * b + c);
                exp_im[b][c] = 32 * (63 - (16 * b + c));
            end
        end
        send_block(1'b1);
        wait_drain();

        // Reset after two beats of a full-scale block: nothing may come out,
        // and the following block's index must ignore the discarded beats.
        set_all(-(1 << 24), -(1 << 24), 0, 0, 0);
        drive_beat(0);
        drive_beat(1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        set_all(4096, 4096, 1024, 1024, 11);
        send_block(1'b0);
        idle(1);
        wait_drain();
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cbfp_blk_norm.md
# cbfp_blk_norm

Multi-beat convergent block-floating-point normaliser for the FFT datapath. It is the parametrised successor to the single-beat CBFP stage. A block of `NCHAN*BLK_CYCLES` complex samples arrives over `BLK_CYCLES` valid beats. The block is ping-pong buffered, and each sample is shifted by the block-common sign-bit count, then rounded and saturated to `OUT_W`. The block is re-emitted as a contiguous burst with one shift index per block.

## Interface
Parameters:
- `IN_W`, 25: input sample width, signed <12.13>.
- `OUT_W`, 12: output sample width, signed <6.6>.
- `NCHAN`, 16: samples per beat (re and im each).
- `BLK_CYCLES`, 4: beats per CBFP block, ≥1.
- `IDX_W`, `$clog2(IN_W)`: shift-index width.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in, 1: clock.
- `rst` in, 1: async active-high reset.
- `valid_in` in, 1: input beat strobe; gaps allowed.
- `data_re_in` in, `[IN_W-1:0]` signed × `NCHAN`: real samples.
- `data_im_in` in, `[IN_W-1:0]` signed × `NCHAN`: imaginary samples.
- `valid_out` out, 1: output beat strobe.
- `data_re_out` out, `[OUT_W-1:0]` signed × `NCHAN`: normalised real.
- `data_im_out` out, `[OUT_W-1:0]` signed × `NCHAN`: normalised imaginary.
- `blk_idx` out, `IDX_W`: block shift index, constant across the burst.
- `sop` out, 1: first beat of burst.
- `eop` out, 1: last beat of burst.

## Operation
- **Sign-bit count** `cnt(x)`: the number of bits below the MSB that equal the MSB, range 0..`IN_W-1`. Values 0 and -1 give `IN_W-1`.
- **Beat min**: the minimum of `cnt` over all 2·`NCHAN` re/im values of the beat.
- **Block min**: a running minimum of the beat mins. It is initialised to `IN_W-1` at each block start.
- **Beat counter**: 0..`BLK_CYCLES-1`, advances on each accepted beat and wraps at the block end.
- **Fill**: beats are written to the fill bank at address equal to the beat counter. At the block end the banks swap, and the final block min is latched as `blk_idx` for the drain bank.
- **Drain**: reads the drain bank for `BLK_CYCLES` consecutive cycles, regardless of input gaps.
- **Per-sample output**: `y = sat_OUT_W(round((x <<< blk_idx) >>> (IN_W-OUT_W)))`. The shift is done in `IN_W` bits; the shift cannot overflow because `blk_idx` ≤ `cnt(x)`.
- **Drain FSM**: `IDLE` → `DRAIN` on bank swap. The FSM stays in `DRAIN` for `BLK_CYCLES` beats, then returns to `IDLE`, or re-enters `DRAIN` if a swap is pending.
- **No overlap**: a block takes ≥`BLK_CYCLES` cycles to fill and `BLK_CYCLES` to drain, so fill and drain never collide. No backpressure is needed.
- **Reset**: async `rst` discards any partial block and both banks. The counter returns to 0, the running min to `IN_W-1`, and the FSM to `IDLE`.

## Timing
- Pipeline, from the input side:
  - Stage 1 registers the beat data and beat min.
  - Stage 2 writes the bank and updates the running min.
  - Stage 3 is the registered output.
- `valid_out` rises on the 3rd rising edge after the edge that samples the block's last beat. It then stays high for exactly `BLK_CYCLES` cycles.
- `sop` is high with beat 0 and `eop` with beat `BLK_CYCLES-1`. When `BLK_CYCLES`=1, both are high together.
- Back-to-back blocks without gaps produce a continuous `valid_out`, with `eop` immediately followed by `sop`.
- Reset values: `valid_out`, `sop`, `eop` = 0; `data_*_out` = 0; `blk_idx` = 0.
- A reset asserted mid-drain truncates the burst immediately; no further beats of that block are emitted.
- A `valid_in` beat in the same cycle as a bank swap is the first beat of the next block.

## Configuration
- `CBFP_ROUND_EN` defined: round half up by adding `1<<(IN_W-OUT_W-1)` before the arithmetic shift, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Not defined: plain truncation (arithmetic right shift), with saturation still applied.
- Latency is identical in both cases.

## Structure
- **`cbfp_pkg`**: holds the `cnt` function, the `IDX_W` helper, the drain-FSM state enum, and the saturate/round functions.
- **`cbfp_beat_min`** (sub-module): computes the combinational `cnt` for 2·`NCHAN` values plus the min tree. It is instantiated once and registered in stage 1.
- **Top level**: the two banks are register arrays inside the top level, sized `2×BLK_CYCLES×NCHAN×2×IN_W`.

## Test plan
All scenarios use the defaults (`IN_W`=25, `OUT_W`=12, `NCHAN`=16, `BLK_CYCLES`=4).
- **Uniform block**: all samples 4096 over 4 beats → `blk_idx`=11, all outputs 1024. `valid_out` is high for 4 cycles starting 3 edges after the last input, with `sop` on the first beat and `eop` on the last.
- **Full-scale sample**: -2^24 placed in beat 2, all others 8192 → `blk_idx`=0. The full-scale sample gives -2048; all others give 1.
- **All-zero block** → `blk_idx`=24, all outputs 0.
- **Rounding and saturation**: a block containing 2^24-1 (forces `blk_idx`=0) and 4096.
  - With `CBFP_ROUND_EN`: outputs are 2047 (saturated) and 1.
  - Without it: outputs are 2047 and 0.
- **Gapped input**: two blocks with `valid_in` toggling 1,0,1,0 → two bursts of 4 contiguous beats each, data in order, correct `sop`/`eop`.
- **Reset mid-fill**: assert `rst` after 2 beats of a block → no output. The next full block normalises correctly, and `blk_idx` is computed only from post-reset beats.
